seven_segment_mux_driver: RTL and testbench

//  Time-multiplexed driver for NUM_DIGITS common-anode/cathode seven-segment digits.

---
 rtl/seven_segment_mux_driver.sv | 184 ++++++++++++++++++
 tb/tb_seven_segment_mux_driver.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_mux_driver.sv
// rtl/seven_segment_mux_driver.sv - time-multiplexed seven-segment digit driver
// Purpose: captures a packed BCD word on i_load and scans the digits one at a time
//   onto shared segment pins, with a one-hot digit select and an optional all-off
//   gap between digits to suppress ghosting.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits
//   (digit 0 is always shown; dp of a blanked digit is still driven).
// Ports:
//   i_clk        rising-edge clock
//   i_reset      synchronous, active-high reset
//   i_enable     0: display dark, scan frozen (load still honoured)
//   i_load       1-cycle strobe capturing i_digits_in / i_dp_in
//   i_digits_in  4*NUM_DIGITS BCD digits, [3:0] = digit 0 (rightmost)
//   i_dp_in      decimal point per digit
//   o_segments   {a,b,c,d,e,f,g} of the lit digit, registered
//   o_dp         decimal point of the lit digit, registered
//   o_digit_sel  one-hot select of the lit digit, registered
//   o_frame_done 1-cycle pulse when the last digit's lit period ends
module seven_segment_mux_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 1000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int SEL_ACTIVE_LOW = 0
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic                      i_load,
    input  logic [4*NUM_DIGITS-1:0]   i_digits_in,
    input  logic [NUM_DIGITS-1:0]     i_dp_in,
    output logic [6:0]                o_segments,
    output logic                      o_dp,
    output logic [NUM_DIGITS-1:0]     o_digit_sel,
    output logic                      o_frame_done
);

    localparam int PW = $clog2(CLK_DIV + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int GW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    // Pin-level "off" values; XOR with these applies the output polarity.
    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

    typedef enum logic {ST_SHOW, ST_GAP} state_t;

    state_t                    r_state;
    logic [IW-1:0]             r_idx;
    logic [PW-1:0]             r_presc;
    logic [GW-1:0]             r_gap;
    logic [4*NUM_DIGITS-1:0]   r_digits;
    logic [NUM_DIGITS-1:0]     r_dps;
    logic [6:0]                r_cur_seg;
    logic                      r_cur_dp;

    logic [3:0]                w_digit;
    logic                      w_digit_dp;
    logic [NUM_DIGITS-1:0]     w_sel;
    logic                      w_lz_blank;
    logic [6:0]                w_dec;
    logic [6:0]                w_show_seg;
    logic                      w_show_dp;
    logic [IW-1:0]             w_idx_next;
`ifdef LEADING_ZERO_BLANK_EN
    logic                      w_upper_zero;
`endif

    always_comb begin
        w_digit    = 4'hF;
        w_digit_dp = 1'b0;
        w_sel      = '0;
        w_lz_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IW'(k)) begin
                w_digit    = r_digits[4*k +: 4];
                w_digit_dp = r_dps[k];
                w_sel[k]   = 1'b1;
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        // Walking down from the top digit, a digit stays a leading zero only
        // while every digit above it is zero too; digit 0 is never blanked.
        w_upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_upper_zero = w_upper_zero && (r_digits[4*k +: 4] == 4'h0);
            if (r_idx == IW'(k)) begin
                w_lz_blank = w_upper_zero;
            end
        end
`endif

        w_dec = 7'b0000000;
        case (w_digit)
            4'd0:    w_dec = 7'b1111110;
            4'd1:    w_dec = 7'b0110000;
            4'd2:    w_dec = 7'b1101101;
            4'd3:    w_dec = 7'b1111001;
            4'd4:    w_dec = 7'b0110011;
            4'd5:    w_dec = 7'b1011011;
            4'd6:    w_dec = 7'b1011111;
            4'd7:    w_dec = 7'b1110000;
            4'd8:    w_dec = 7'b1111111;
            4'd9:    w_dec = 7'b1111011;
            default: w_dec = 7'b0000000;
        endcase
        if (w_lz_blank) begin
            w_dec = 7'b0000000;
        end

        // The pattern is sampled from the shadow only on the first lit cycle of a
        // period and then held, so a load never changes a digit mid-period.
        w_show_seg = (r_presc == '0) ? w_dec      : r_cur_seg;
        w_show_dp  = (r_presc == '0) ? w_digit_dp : r_cur_dp;
        w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_SHOW;
            r_idx        <= '0;
            r_presc      <= '0;
            r_gap        <= '0;
            r_digits     <= {NUM_DIGITS{4'hF}};
            r_dps        <= '0;
            r_cur_seg    <= 7'b0000000;
            r_cur_dp     <= 1'b0;
            o_segments   <= SEG_OFF;
            o_dp         <= DP_OFF;
            o_digit_sel  <= SEL_OFF;
            o_frame_done <= 1'b0;
        end else begin
            if (i_load) begin
                r_digits <= i_digits_in;
                r_dps    <= i_dp_in;
            end
            o_frame_done <= 1'b0;

            if (!i_enable) begin
                o_segments  <= SEG_OFF;
                o_dp        <= DP_OFF;
                o_digit_sel <= SEL_OFF;
            end else begin
                case (r_state)
                    ST_SHOW: begin
                        o_segments  <= w_show_seg ^ SEG_OFF;
                        o_dp        <= w_show_dp ^ DP_OFF;
                        o_digit_sel <= w_sel ^ SEL_OFF;
                        r_cur_seg   <= w_show_seg;
                        r_cur_dp    <= w_show_dp;
                        if (r_presc == PRESC_LAST) begin
                            r_presc      <= '0;
                            o_frame_done <= (r_idx == IDX_LAST);
                            if (BLANK_CYCLES == 0) begin
                                r_idx <= w_idx_next;
                            end else begin
                                r_state <= ST_GAP;
                            end
                        end else begin
                            r_presc <= r_presc + 1'b1;
                        end
                    end
                    default: begin
                        o_segments  <= SEG_OFF;
                        o_dp        <= DP_OFF;
                        o_digit_sel <= SEL_OFF;
                        if (r_gap == GAP_LAST) begin
                            r_gap   <= '0;
                            r_state <= ST_SHOW;
                            r_idx   <= w_idx_next;
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_mux_driver.sv
// tb/tb_seven_segment_mux_driver.sv - scoreboard bench for seven_segment_mux_driver
module tb_seven_segment_mux_driver;

    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int BLK = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;

    logic [6:0]  a_seg;
    logic        a_dp;
    logic [3:0]  a_sel;
    logic        a_fd;
    logic [6:0]  b_seg;
    logic        b_dp;
    logic [3:0]  b_sel;
    logic        b_fd;

    always #5 clk = ~clk;

    seven_segment_mux_driver #(
        .NUM_DIGITS(N), .CLK_DIV(DIV), .BLANK_CYCLES(BLK),
        .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)
    ) u_dut (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_load(load),
        .i_digits_in(digits_in), .i_dp_in(dp_in),
        .o_segments(a_seg), .o_dp(a_dp), .o_digit_sel(a_sel), .o_frame_done(a_fd)
    );

    seven_segment_mux_driver #(
        .NUM_DIGITS(N), .CLK_DIV(DIV), .BLANK_CYCLES(BLK),
        .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
    ) u_dut_inv (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_load(load),
        .i_digits_in(digits_in), .i_dp_in(dp_in),
        .o_segments(b_seg), .o_dp(b_dp), .o_digit_sel(b_sel), .o_frame_done(b_fd)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] sel;
        logic       fd;
    } exp_t;

    exp_t        sb_q[$];
    logic [6:0]  dec_tab [16];

    // Reference model: lit cycles remaining, gap cycles remaining, latched pattern.
    int          m_show;
    int          m_idx;
    int          m_left;
    int          m_gapleft;
    logic [15:0] m_dig;
    logic [3:0]  m_dps;
    logic [6:0]  m_seg;
    logic        m_dp;

    int          n_vec = 0;
    int          n_err = 0;
    string       phase;

    task automatic expect_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic lz_blank(input int idx, input logic [15:0] d);
        logic hit;
        hit = (idx != 0);
        for (int k = idx; k < N; k++) begin
            if (d[4*k +: 4] != 4'h0) hit = 1'b0;
        end
`ifdef LEADING_ZERO_BLANK_EN
        return hit;
`else
        return hit & 1'b0;
`endif
    endfunction

    task automatic step(input logic rst, input logic en, input logic ld,
                        input logic [15:0] dig, input logic [3:0] dpv);
        exp_t e;
        exp_t got_e;
        @(negedge clk);
        reset     = rst;
        enable    = en;
        load      = ld;
        digits_in = dig;
        dp_in     = dpv;
        e = '0;
        if (rst) begin
            m_show = 1; m_idx = 0; m_left = DIV; m_gapleft = 0;
            m_dig = 16'hFFFF; m_dps = 4'b0000; m_seg = 7'b0; m_dp = 1'b0;
        end else begin
            if (en) begin
                if (m_show != 0) begin
                    if (m_left == DIV) begin
                        m_seg = lz_blank(m_idx, m_dig) ? 7'b0 : dec_tab[m_dig[4*m_idx +: 4]];
                        m_dp  = m_dps[m_idx];
                    end
                    e.seg = m_seg;
                    e.dp  = m_dp;
                    e.sel = 4'(1 << m_idx);
                    m_left--;
                    if (m_left == 0) begin
                        e.fd   = (m_idx == N - 1);
                        m_left = DIV;
                        if (BLK > 0) begin
                            m_show = 0; m_gapleft = BLK;
                        end else begin
                            m_idx = (m_idx + 1) % N;
                        end
                    end
                end else begin
                    m_gapleft--;
                    if (m_gapleft == 0) begin
                        m_show = 1;
                        m_idx  = (m_idx + 1) % N;
                    end
                end
            end
            if (ld) begin
                m_dig = dig;
                m_dps = dpv;
            end
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got_e = sb_q.pop_front();
        expect_eq({phase, "_pos"}, {3'b000, a_seg, a_dp, a_sel, a_fd}, 16'(got_e));
        expect_eq({phase, "_neg"}, {3'b000, b_seg, b_dp, b_sel, b_fd},
                  16'({got_e.seg ^ 7'h7F, ~got_e.dp, got_e.sel ^ 4'hF, got_e.fd}));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 16'h0000, 4'b0000);
    endtask

    task automatic wait_for(input int idx, input int left);
        for (int i = 0; i < 60 && !(m_show != 0 && m_idx == idx && m_left == left); i++)
            step(1'b0, 1'b1, 1'b0, 16'h0000, 4'b0000);
    endtask

    initial begin
        dec_tab[0]  = 7'b1111110; dec_tab[1]  = 7'b0110000;
        dec_tab[2]  = 7'b1101101; dec_tab[3]  = 7'b1111001;
        dec_tab[4]  = 7'b0110011; dec_tab[5]  = 7'b1011011;
        dec_tab[6]  = 7'b1011111; dec_tab[7]  = 7'b1110000;
        dec_tab[8]  = 7'b1111111; dec_tab[9]  = 7'b1111011;
        for (int i = 10; i < 16; i++) dec_tab[i] = 7'b0000000;

        reset = 1'b1; enable = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0;

        phase = "reset";
        repeat (3) step(1'b1, 1'b1, 1'b0, 16'h0000, 4'b0000);

        phase = "scan_blank";
        run(45);

        phase = "load_1234";
        step(1'b0, 1'b1, 1'b1, 16'h1234, 4'b0100);
        run(44);

        phase = "load_mid";
        wait_for(1, 2);
        step(1'b0, 1'b1, 1'b1, 16'h5678, 4'b0010);
        run(30);

        phase = "enable_low";
        wait_for(2, 2);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 4'b0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 4'b0000);
        step(1'b0, 1'b0, 1'b1, 16'h4321, 4'b1000);
        repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0000, 4'b0000);
        run(30);

        phase = "frame_load";
        wait_for(3, 1);
        step(1'b0, 1'b1, 1'b1, 16'h9876, 4'b1001);
        run(25);

        phase = "polarity_00A5";
        step(1'b0, 1'b1, 1'b1, 16'h00A5, 4'b0000);
        run(25);

        phase = "lz_0007";
        step(1'b0, 1'b1, 1'b1, 16'h0007, 4'b0000);
        run(22);

        phase = "lz_0000";
        step(1'b0, 1'b1, 1'b1, 16'h0000, 4'b0100);
        run(22);

        phase = "lz_0300";
        step(1'b0, 1'b1, 1'b1, 16'h0300, 4'b0000);
        run(22);

        phase = "random";
        for (int i = 0; i < 120; i++)
            step(1'b0, ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
                 16'($urandom), 4'($urandom));

        phase = "reset_mid";
        wait_for(2, 3);
        step(1'b1, 1'b1, 1'b0, 16'h0000, 4'b0000);
        run(25);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
